vga_timing_gen: RTL and testbench

VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

---
 rtl/vga_timing_pkg.sv | 54 +++++
 rtl/vga_axis_counter.sv | 57 +++++
 rtl/vga_timing_gen.sv | 144 ++++++++++++++
 tb/tb_vga_timing_gen.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_timing_pkg.sv
// Shared types and 640x480@60 default timing constants for the VGA timing generator.
// Axis phase encoding is common to both axes and maps one-to-one onto h_state_t / v_state_t.
package vga_timing_pkg;

    localparam int DEF_H_ACTIVE  = 640;
    localparam int DEF_H_FP      = 16;
    localparam int DEF_H_SYNC    = 96;
    localparam int DEF_H_BP      = 48;
    localparam int DEF_V_ACTIVE  = 480;
    localparam int DEF_V_FP      = 10;
    localparam int DEF_V_SYNC    = 2;
    localparam int DEF_V_BP      = 33;
    localparam int DEF_HS_POL    = 0;
    localparam int DEF_VS_POL    = 0;
    localparam int DEF_CW        = 11;
    localparam int DEF_ALIGN_DLY = 2;

    typedef enum logic [1:0] {
        PH_ACT  = 2'd0,
        PH_FP   = 2'd1,
        PH_SYNC = 2'd2,
        PH_BP   = 2'd3
    } axis_phase_t;

    typedef enum logic [1:0] {
        H_ACT = 2'd0,
        H_FPO = 2'd1,
        H_SYN = 2'd2,
        H_BPO = 2'd3
    } h_state_t;

    typedef enum logic [1:0] {
        V_ACT = 2'd0,
        V_FPO = 2'd1,
        V_SYN = 2'd2,
        V_BPO = 2'd3
    } v_state_t;

    // Registered video control bundle; blank is kept explicitly so it is a true flop output.
    typedef struct packed {
        logic hs;
        logic vs;
        logic de;
        logic blank;
        logic line_start;
        logic frame_start;
    } video_ctl_t;

    function automatic longint axis_total(input int active, input int fp,
                                          input int sync, input int bp);
        return longint'(active) + longint'(fp) + longint'(sync) + longint'(bp);
    endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// One timing axis: a position counter 0..TOTAL-1 plus a four-phase FSM
// (active, front porch, sync, back porch). Both advance only when step=1.
module vga_axis_counter
    import vga_timing_pkg::*;
#(
    parameter int ACTIVE = DEF_H_ACTIVE,
    parameter int FP     = DEF_H_FP,
    parameter int SYNC   = DEF_H_SYNC,
    parameter int BP     = DEF_H_BP,
    parameter int CW     = DEF_CW
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          step,
    output logic [CW-1:0] count,
    output axis_phase_t   phase
);

    localparam longint TOTAL = axis_total(ACTIVE, FP, SYNC, BP);

    localparam logic [CW-1:0] END_ACT  = CW'(ACTIVE - 1);
    localparam logic [CW-1:0] END_FP   = CW'(ACTIVE + FP - 1);
    localparam logic [CW-1:0] END_SYNC = CW'(ACTIVE + FP + SYNC - 1);
    localparam logic [CW-1:0] END_TOT  = CW'(TOTAL - 1);

    axis_phase_t phase_nxt;
    logic        at_end;

    assign at_end = (count == END_TOT);

    // Each phase ends on its last position, so the next phase starts on the following step.
    always_comb begin
        phase_nxt = phase;
        if (step) begin
            case (phase)
                PH_ACT:  if (count == END_ACT)  phase_nxt = PH_FP;
                PH_FP:   if (count == END_FP)   phase_nxt = PH_SYNC;
                PH_SYNC: if (count == END_SYNC) phase_nxt = PH_BP;
                PH_BP:   if (at_end)            phase_nxt = PH_ACT;
                default:                        phase_nxt = PH_ACT;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
            phase <= PH_ACT;
        end else begin
            phase <= phase_nxt;
            if (step) begin
                count <= at_end ? '0 : count + 1'b1;
            end
        end
    end

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: column/line counters, sync, data enable and start pulses.
// Optional macro VGA_TIMING_GEN_ALIGN_EN adds an ALIGN_DLY-stage delay on the control outputs.
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int H_ACTIVE  = DEF_H_ACTIVE,
    parameter int H_FP      = DEF_H_FP,
    parameter int H_SYNC    = DEF_H_SYNC,
    parameter int H_BP      = DEF_H_BP,
    parameter int V_ACTIVE  = DEF_V_ACTIVE,
    parameter int V_FP      = DEF_V_FP,
    parameter int V_SYNC    = DEF_V_SYNC,
    parameter int V_BP      = DEF_V_BP,
    parameter int HS_POL    = DEF_HS_POL,
    parameter int VS_POL    = DEF_VS_POL,
    parameter int CW        = DEF_CW,
    parameter int ALIGN_DLY = DEF_ALIGN_DLY
) (
    input  logic          pixel_clk,
    input  logic          rst_n,
    input  logic          en,
    output logic [CW-1:0] hcount,
    output logic [CW-1:0] vcount,
    output logic          hs,
    output logic          vs,
    output logic          de,
    output logic          blank,
    output logic          line_start,
    output logic          frame_start,
    output h_state_t      h_state,
    output v_state_t      v_state
);

    localparam longint H_TOTAL = axis_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
    localparam longint V_TOTAL = axis_total(V_ACTIVE, V_FP, V_SYNC, V_BP);
    localparam longint CAP     = longint'(1) << CW;

    if (H_ACTIVE <= 0 || H_FP <= 0 || H_SYNC <= 0 || H_BP <= 0 ||
        V_ACTIVE <= 0 || V_FP <= 0 || V_SYNC <= 0 || V_BP <= 0 || CW <= 0) begin : g_bad_zero
        $error("vga_timing_gen: timing parameters and CW must be non-zero");
    end
    if (H_TOTAL > CAP || V_TOTAL > CAP) begin : g_bad_width
        $error("vga_timing_gen: H_TOTAL or V_TOTAL does not fit in CW bits");
    end
    // Range kept valid in both builds so the macro can be toggled without re-parameterising.
    if (ALIGN_DLY < 1 || ALIGN_DLY > 8) begin : g_bad_align
        $error("vga_timing_gen: ALIGN_DLY must be in 1..8");
    end

`ifdef VGA_TIMING_GEN_ALIGN_EN
    localparam int NSTG = 1 + ALIGN_DLY;
`else
    localparam int NSTG = 1;
`endif

    localparam logic          HS_ON  = (HS_POL != 0);
    localparam logic          VS_ON  = (VS_POL != 0);
    localparam logic [CW-1:0] H_LAST = CW'(H_TOTAL - 1);

    localparam video_ctl_t CTL_RST = '{
        hs:          !HS_ON,
        vs:          !VS_ON,
        de:          1'b0,
        blank:       1'b1,
        line_start:  1'b0,
        frame_start: 1'b0
    };

    axis_phase_t h_phase;
    axis_phase_t v_phase;
    logic        h_wrap;
    video_ctl_t  ctl_nxt;
    video_ctl_t  stg [NSTG];

    assign h_wrap = en && (hcount == H_LAST);

    vga_axis_counter #(
        .ACTIVE (H_ACTIVE),
        .FP     (H_FP),
        .SYNC   (H_SYNC),
        .BP     (H_BP),
        .CW     (CW)
    ) u_h_axis (
        .clk   (pixel_clk),
        .rst_n (rst_n),
        .step  (en),
        .count (hcount),
        .phase (h_phase)
    );

    vga_axis_counter #(
        .ACTIVE (V_ACTIVE),
        .FP     (V_FP),
        .SYNC   (V_SYNC),
        .BP     (V_BP),
        .CW     (CW)
    ) u_v_axis (
        .clk   (pixel_clk),
        .rst_n (rst_n),
        .step  (h_wrap),
        .count (vcount),
        .phase (v_phase)
    );

    assign h_state = h_state_t'(h_phase);
    assign v_state = v_state_t'(v_phase);

    // Decode of the current position; captured into stage 0 on enabled cycles.
    always_comb begin
        ctl_nxt             = CTL_RST;
        ctl_nxt.hs          = (h_phase == PH_SYNC) ? HS_ON : !HS_ON;
        ctl_nxt.vs          = (v_phase == PH_SYNC) ? VS_ON : !VS_ON;
        ctl_nxt.de          = (h_phase == PH_ACT) && (v_phase == PH_ACT);
        ctl_nxt.blank       = !ctl_nxt.de;
        ctl_nxt.line_start  = (hcount == '0);
        ctl_nxt.frame_start = (hcount == '0) && (vcount == '0);
    end

    // The chain advances only with en. On a held cycle the output stage drops its pulses
    // (they were already shown for one cycle); inner stages keep theirs for the next advance.
    always_ff @(posedge pixel_clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NSTG; i++) begin
                stg[i] <= CTL_RST;
            end
        end else if (en) begin
            stg[0] <= ctl_nxt;
            for (int i = 1; i < NSTG; i++) begin
                stg[i] <= stg[i-1];
            end
        end else begin
            stg[NSTG-1].line_start  <= 1'b0;
            stg[NSTG-1].frame_start <= 1'b0;
        end
    end

    assign hs          = stg[NSTG-1].hs;
    assign vs          = stg[NSTG-1].vs;
    assign de          = stg[NSTG-1].de;
    assign blank       = stg[NSTG-1].blank;
    assign line_start  = stg[NSTG-1].line_start;
    assign frame_start = stg[NSTG-1].frame_start;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench for vga_timing_gen: a small-raster instance, its inverted-polarity twin and
// a default 640x480 instance, checked against hand tables and a position model.
module tb_vga_timing_gen;
    import vga_timing_pkg::*;

`ifdef VGA_TIMING_GEN_ALIGN_EN
    localparam int LAT = 3;
`else
    localparam int LAT = 1;
`endif

    typedef struct packed {
        int ha; int hf; int hs; int hb;
        int va; int vf; int vs; int vb;
    } geom_t;

    typedef struct packed {
        logic [10:0] hc;
        logic [10:0] vc;
        logic [1:0]  hst;
        logic [1:0]  vst;
    } pos_t;

    typedef struct packed {
        logic hs; logic vs; logic de; logic blank; logic ls; logic fs;
    } ctl_t;

    typedef struct {
        int          t;
        logic [10:0] hc;
        logic [10:0] vc;
        ctl_t        st;
    } vec_t;

    localparam geom_t G_S = '{ha: 8, hf: 2, hs: 3, hb: 3, va: 4, vf: 1, vs: 2, vb: 1};
    localparam geom_t G_D = '{ha: 640, hf: 16, hs: 96, hb: 48, va: 480, vf: 10, vs: 2, vb: 33};
    localparam int NV = 17;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n;
    logic en;
    always #5 clk = ~clk;

    logic [10:0] hc_s, vc_s, hc_p, vc_p, hc_d, vc_d;
    logic hs_s, vs_s, de_s, bl_s, ls_s, fs_s;
    logic hs_p, vs_p, de_p, bl_p, ls_p, fs_p;
    logic hs_d, vs_d, de_d, bl_d, ls_d, fs_d;
    h_state_t hst_s, hst_p, hst_d;
    v_state_t vst_s, vst_p, vst_d;

    vga_timing_gen #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
        .HS_POL(0), .VS_POL(0), .CW(11), .ALIGN_DLY(2)
    ) dut_s (
        .pixel_clk(clk), .rst_n(rst_n), .en(en), .hcount(hc_s), .vcount(vc_s),
        .hs(hs_s), .vs(vs_s), .de(de_s), .blank(bl_s), .line_start(ls_s),
        .frame_start(fs_s), .h_state(hst_s), .v_state(vst_s)
    );

    vga_timing_gen #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
        .HS_POL(1), .VS_POL(1), .CW(11), .ALIGN_DLY(2)
    ) dut_p (
        .pixel_clk(clk), .rst_n(rst_n), .en(en), .hcount(hc_p), .vcount(vc_p),
        .hs(hs_p), .vs(vs_p), .de(de_p), .blank(bl_p), .line_start(ls_p),
        .frame_start(fs_p), .h_state(hst_p), .v_state(vst_p)
    );

    vga_timing_gen #(
        .ALIGN_DLY(2)
    ) dut_d (
        .pixel_clk(clk), .rst_n(rst_n), .en(en), .hcount(hc_d), .vcount(vc_d),
        .hs(hs_d), .vs(vs_d), .de(de_d), .blank(bl_d), .line_start(ls_d),
        .frame_start(fs_d), .h_state(hst_d), .v_state(vst_d)
    );

    // ---------------- bookkeeping ----------------
    int checks = 0;
    int errors = 0;
    int k, cyc;
    bit pe;
    bit tbl_on;
    int d_last_ls, d_de_cnt, d_hs_fall, s_last_fs;
    int s_first_de, d_first_de, s_first_fs;
    logic d_hs_prev;
    vec_t vecs [NV];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d k=%0d: got %0h expected %0h", name, cyc, k, act, exp);
        end
    endtask

    // ---------------- model ----------------
    function automatic int ph(input int c, input int a, input int f, input int s);
        if (c < a) return 0;
        if (c < a + f) return 1;
        if (c < a + f + s) return 2;
        return 3;
    endfunction

    function automatic pos_t exp_pos(input int kk, input geom_t g);
        pos_t r;
        int ht, vt, col, line;
        ht = g.ha + g.hf + g.hs + g.hb;
        vt = g.va + g.vf + g.vs + g.vb;
        col = kk % ht;
        line = (kk / ht) % vt;
        r.hc = 11'(col);
        r.vc = 11'(line);
        r.hst = 2'(ph(col, g.ha, g.hf, g.hs));
        r.vst = 2'(ph(line, g.va, g.vf, g.vs));
        return r;
    endfunction

    function automatic ctl_t exp_ctl(input int kk, input bit pen, input geom_t g,
                                     input bit hp, input bit vp);
        ctl_t r;
        int ht, vt, p, col, line;
        r = '{hs: ~hp, vs: ~vp, de: 1'b0, blank: 1'b1, ls: 1'b0, fs: 1'b0};
        if (kk < LAT) return r;
        ht = g.ha + g.hf + g.hs + g.hb;
        vt = g.va + g.vf + g.vs + g.vb;
        p = kk - LAT;
        col = p % ht;
        line = (p / ht) % vt;
        r.hs = (ph(col, g.ha, g.hf, g.hs) == 2) ? hp : ~hp;
        r.vs = (ph(line, g.va, g.vf, g.vs) == 2) ? vp : ~vp;
        r.de = (col < g.ha) && (line < g.va);
        r.blank = ~r.de;
        r.ls = pen && (col == 0);
        r.fs = r.ls && (line == 0);
        return r;
    endfunction

    function automatic vec_t mk(input int t, input int hc, input int vc, input bit h,
                                input bit v, input bit d, input bit l, input bit f);
        vec_t r;
        r.t = t;
        r.hc = 11'(hc);
        r.vc = 11'(vc);
        r.st = '{hs: h, vs: v, de: d, blank: ~d, ls: l, fs: f};
        return r;
    endfunction

    // ---------------- driver / checker tasks ----------------
    task automatic sample(input int mode);
        int ls_period, fs_period;
        ls_period = (mode == 1) ? 1600 : 800;
        fs_period = (mode == 1) ? 256 : 128;

        check("s_pos", 64'({hc_s, vc_s, hst_s, vst_s}), 64'(exp_pos(k, G_S)));
        check("s_ctl", 64'({hs_s, vs_s, de_s, bl_s, ls_s, fs_s}), 64'(exp_ctl(k, pe, G_S, 1'b0, 1'b0)));
        check("p_pos", 64'({hc_p, vc_p, hst_p, vst_p}), 64'(exp_pos(k, G_S)));
        check("p_ctl", 64'({hs_p, vs_p, de_p, bl_p, ls_p, fs_p}), 64'(exp_ctl(k, pe, G_S, 1'b1, 1'b1)));
        check("d_pos", 64'({hc_d, vc_d, hst_d, vst_d}), 64'(exp_pos(k, G_D)));
        check("d_ctl", 64'({hs_d, vs_d, de_d, bl_d, ls_d, fs_d}), 64'(exp_ctl(k, pe, G_D, 1'b0, 1'b0)));

        if (tbl_on) begin
            for (int i = 0; i < NV; i++) begin
                if (vecs[i].t == k)
                    check($sformatf("tbl_pos_%0d", vecs[i].t), 64'({hc_s, vc_s}), 64'({vecs[i].hc, vecs[i].vc}));
                if (vecs[i].t + LAT == k)
                    check($sformatf("tbl_ctl_%0d", vecs[i].t), 64'({hs_s, vs_s, de_s, bl_s, ls_s, fs_s}), 64'(vecs[i].st));
            end
        end

        if (ls_d) begin
            if (d_last_ls >= 0) begin
                check("d_ls_period", 64'(cyc - d_last_ls), 64'(ls_period));
                if (mode == 0) check("d_de_per_line", 64'(d_de_cnt), 64'(640));
            end
            d_last_ls = cyc;
            d_de_cnt = 0;
        end
        if (mode == 0 && de_d) d_de_cnt++;
        if (mode == 0) begin
            if (d_hs_prev && !hs_d) begin
                if (d_last_ls >= 0) check("d_hs_offset", 64'(cyc - d_last_ls), 64'(656));
                d_hs_fall = cyc;
            end
            if (!d_hs_prev && hs_d && d_hs_fall >= 0) check("d_hs_width", 64'(cyc - d_hs_fall), 64'(96));
        end
        d_hs_prev = hs_d;

        if (fs_s) begin
            if (s_last_fs >= 0) check("s_fs_period", 64'(cyc - s_last_fs), 64'(fs_period));
            s_last_fs = cyc;
            if (s_first_fs < 0) s_first_fs = cyc;
        end
        if (de_s && s_first_de < 0) s_first_de = cyc;
        if (de_d && d_first_de < 0) d_first_de = cyc;
    endtask

    // mode 0: en always 1; mode 1: en pattern 1,0,0,1; mode 2: en held 0
    task automatic run(input int ncyc, input int mode);
        for (int n = 0; n < ncyc; n++) begin
            sample(mode);
            case (mode)
                0:       en = 1'b1;
                1:       en = ((cyc % 4) == 0) || ((cyc % 4) == 3);
                default: en = 1'b0;
            endcase
            pe = en;
            if (en) k++;
            cyc++;
            @(negedge clk);
            #1;
        end
    endtask

    task automatic check_rst(input string tag);
        check({tag, "_s_pos"}, 64'({hc_s, vc_s, hst_s, vst_s}), 64'(0));
        check({tag, "_s_ctl"}, 64'({hs_s, vs_s, de_s, bl_s, ls_s, fs_s}), 64'(6'b110100));
        check({tag, "_p_ctl"}, 64'({hs_p, vs_p, de_p, bl_p, ls_p, fs_p}), 64'(6'b000100));
        check({tag, "_d_pos"}, 64'({hc_d, vc_d, hst_d, vst_d}), 64'(0));
        check({tag, "_d_ctl"}, 64'({hs_d, vs_d, de_d, bl_d, ls_d, fs_d}), 64'(6'b110100));
    endtask

    // Called at negedge+1; asserts reset, checks it took effect before the next edge, releases.
    task automatic do_reset(input string tag);
        rst_n = 1'b0;
        en = 1'b0;
        #1;
        check_rst(tag);
        repeat (2) begin
            @(negedge clk);
            #1;
        end
        rst_n = 1'b1;
        k = 0; pe = 1'b0; cyc = 0;
        d_last_ls = -1; d_de_cnt = 0; d_hs_fall = -1; d_hs_prev = 1'b1;
        s_last_fs = -1; s_first_de = -1; d_first_de = -1; s_first_fs = -1;
    endtask

    // ---------------- test ----------------
    initial begin
        vecs[0]  = mk(0,   0,  0, 1, 1, 1, 1, 1);
        vecs[1]  = mk(7,   7,  0, 1, 1, 1, 0, 0);
        vecs[2]  = mk(8,   8,  0, 1, 1, 0, 0, 0);
        vecs[3]  = mk(10, 10,  0, 0, 1, 0, 0, 0);
        vecs[4]  = mk(12, 12,  0, 0, 1, 0, 0, 0);
        vecs[5]  = mk(13, 13,  0, 1, 1, 0, 0, 0);
        vecs[6]  = mk(15, 15,  0, 1, 1, 0, 0, 0);
        vecs[7]  = mk(16,  0,  1, 1, 1, 1, 1, 0);
        vecs[8]  = mk(63, 15,  3, 1, 1, 0, 0, 0);
        vecs[9]  = mk(64,  0,  4, 1, 1, 0, 1, 0);
        vecs[10] = mk(80,  0,  5, 1, 0, 0, 1, 0);
        vecs[11] = mk(90, 10,  5, 0, 0, 0, 0, 0);
        vecs[12] = mk(111, 15, 6, 1, 0, 0, 0, 0);
        vecs[13] = mk(112, 0,  7, 1, 1, 0, 1, 0);
        vecs[14] = mk(127, 15, 7, 1, 1, 0, 0, 0);
        vecs[15] = mk(128, 0,  0, 1, 1, 1, 1, 1);
        vecs[16] = mk(131, 3,  0, 1, 1, 1, 0, 0);

        tbl_on = 1'b0;
        k = 0; pe = 1'b0; cyc = 0;
        rst_n = 1'b1;
        en = 1'b0;
        #1;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        check_rst("por");
        do_reset("por2");

        // free-running: table, model, line/frame intervals, de-rise latency
        tbl_on = 1'b1;
        run(1800, 0);
        tbl_on = 1'b0;
        check("s_de_rise", 64'(s_first_de), 64'(LAT));
        check("d_de_rise", 64'(d_first_de), 64'(LAT));

        // enable toggled 1,0,0,1: half-rate advance, frozen levels, 1600-clock lines
        do_reset("pre_toggle");
        run(3300, 1);

        // reset asserted mid-line, released with en low, then restarted
        do_reset("pre_mid");
        run(53, 0);
        check("s_mid_pos", 64'({hc_s, vc_s}), 64'({11'd5, 11'd3}));
        do_reset("mid");
        run(3, 2);
        run(300, 0);
        check("s_first_fs", 64'(s_first_fs), 64'(3 + LAT));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
